// File: rtl/axi_addr_arbiter_n.sv
// ---------------------------------------------------------------------------
// axi_addr_arbiter_n
//
// Arbitrates one AXI address channel (AW or AR) among NUM_M masters onto a
// single downstream slave port. A winner is chosen and registered in IDLE.
// It is then presented combinationally in GRANT until the downstream
// handshake completes. With HOLD_W=1 the grant is held after the AW handshake
// (state WAIT_W) until the write data burst finishes (w_done_i).
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   id_m_i    [NUM_M*ID_W]       flattened master IDs (master k in slice k)
//   addr_m_i  [NUM_M*ADDR_W]     flattened master addresses
//   len_m_i   [NUM_M*LEN_W]      flattened burst lengths
//   size_m_i  [NUM_M*SIZE_W]     flattened burst sizes
//   burst_m_i [NUM_M*BURST_W]    flattened burst types
//   valid_m_i [NUM_M]            per-master request valid
//   ready_m_o [NUM_M]            per-master ready (only the granted master)
//   id_o      [IDX_W+ID_W]       {granted index, granted ID}
//   addr_o, len_o, size_o, burst_o   granted request fields
//   valid_o / ready_s_i          downstream handshake
//   w_done_i                     pulse: last write beat accepted downstream
//   grant_o   [NUM_M]            one-hot current grant, zero when idle
//   busy_o                       state is not IDLE
// ---------------------------------------------------------------------------
module axi_addr_arbiter_n #(
  parameter int NUM_M   = 3,
  parameter int ID_W    = 4,
  parameter int ADDR_W  = 32,
  parameter int LEN_W   = 4,
  parameter int SIZE_W  = 3,
  parameter int BURST_W = 2,
  parameter int RR_MODE = 1,
  parameter int HOLD_W  = 0,
  localparam int IDX_W  = (NUM_M > 1) ? $clog2(NUM_M) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_M*ID_W-1:0]    id_m_i,
  input  logic [NUM_M*ADDR_W-1:0]  addr_m_i,
  input  logic [NUM_M*LEN_W-1:0]   len_m_i,
  input  logic [NUM_M*SIZE_W-1:0]  size_m_i,
  input  logic [NUM_M*BURST_W-1:0] burst_m_i,
  input  logic [NUM_M-1:0]         valid_m_i,
  output logic [NUM_M-1:0]         ready_m_o,
  output logic [IDX_W+ID_W-1:0]    id_o,
  output logic [ADDR_W-1:0]        addr_o,
  output logic [LEN_W-1:0]         len_o,
  output logic [SIZE_W-1:0]        size_o,
  output logic [BURST_W-1:0]       burst_o,
  output logic                     valid_o,
  input  logic                     ready_s_i,
  input  logic                     w_done_i,
  output logic [NUM_M-1:0]         grant_o,
  output logic                     busy_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    WAIT_W = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [IDX_W-1:0]   g_idx;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   rr_ptr_nxt;
  logic               any_req;
  logic               g_valid;
  logic               hs;

  logic [ID_W-1:0]    sel_id;
  logic [ADDR_W-1:0]  sel_addr;
  logic [LEN_W-1:0]   sel_len;
  logic [SIZE_W-1:0]  sel_size;
  logic [BURST_W-1:0] sel_burst;

  assign any_req = |valid_m_i;

  // Winner selection. Round-robin scans upward from rr_ptr with wrap and
  // takes the first requester; fixed priority lets the highest index win.
  always_comb begin
    int   cand;
    logic found;
    cand    = 0;
    found   = 1'b0;
    win_idx = '0;
    if (RR_MODE != 0) begin
      for (int i = 0; i < NUM_M; i++) begin
        cand = int'(rr_ptr) + i;
        if (cand >= NUM_M) cand = cand - NUM_M;
        if (!found && valid_m_i[cand]) begin
          found   = 1'b1;
          win_idx = IDX_W'(cand);
        end
      end
    end else begin
      for (int i = 0; i < NUM_M; i++) begin
        if (valid_m_i[i]) win_idx = IDX_W'(i);
      end
    end
  end

  // Mux of the granted master's request fields, driven by the registered
  // grant index so non-granted request changes cannot disturb it.
  always_comb begin
    sel_id    = '0;
    sel_addr  = '0;
    sel_len   = '0;
    sel_size  = '0;
    sel_burst = '0;
    g_valid   = 1'b0;
    for (int k = 0; k < NUM_M; k++) begin
      if (g_idx == IDX_W'(k)) begin
        sel_id    = id_m_i[k*ID_W +: ID_W];
        sel_addr  = addr_m_i[k*ADDR_W +: ADDR_W];
        sel_len   = len_m_i[k*LEN_W +: LEN_W];
        sel_size  = size_m_i[k*SIZE_W +: SIZE_W];
        sel_burst = burst_m_i[k*BURST_W +: BURST_W];
        g_valid   = valid_m_i[k];
      end
    end
  end

  assign hs = (state == GRANT) && g_valid && ready_s_i;

  assign rr_ptr_nxt = (g_idx == IDX_W'(NUM_M - 1)) ? '0 : g_idx + 1'b1;

  // State register plus grant index and round-robin pointer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      g_idx  <= '0;
      rr_ptr <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && any_req) g_idx <= win_idx;
      if (hs) rr_ptr <= rr_ptr_nxt;
    end
  end

  // Next-state logic; w_done_i only matters at a handshake or in WAIT_W
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (any_req) state_nxt = GRANT;
      end
      GRANT: begin
        if (hs) begin
          if (HOLD_W == 0 || w_done_i) state_nxt = IDLE;
          else                         state_nxt = WAIT_W;
        end else if (!g_valid) begin
          state_nxt = IDLE;
        end
      end
      WAIT_W: begin
        if (w_done_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: the granted request passes through only in GRANT; IDLE and
  // WAIT_W drive zeros except for grant_o/busy_o.
  always_comb begin
    ready_m_o = '0;
    id_o      = '0;
    addr_o    = '0;
    len_o     = '0;
    size_o    = '0;
    burst_o   = '0;
    valid_o   = 1'b0;
    grant_o   = '0;
    busy_o    = (state != IDLE);
    for (int k = 0; k < NUM_M; k++) begin
      grant_o[k] = (state != IDLE) && (g_idx == IDX_W'(k));
    end
    if (state == GRANT) begin
      id_o    = {g_idx, sel_id};
      addr_o  = sel_addr;
      len_o   = sel_len;
      size_o  = sel_size;
      burst_o = sel_burst;
      valid_o = g_valid;
      for (int k = 0; k < NUM_M; k++) begin
        if (g_idx == IDX_W'(k)) ready_m_o[k] = ready_s_i & valid_m_i[k];
      end
    end
  end

endmodule
